record_arbiter: RTL and testbench

RECORD_ARBITER -- requirements
Module: record_arbiter

---
 rtl/record_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_record_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/record_arbiter.sv
// Purpose: collects single words from NUM_CH recording channels on rising edges of their
//          valid levels and merges them round-robin into one registered output stream.
// Latency: edge seen at cycle n -> pending at n+1 -> outValid at n+2 (no contention).
// Backpressure: outReady=0 stalls the output register; a channel's second word that arrives
//               while its first is still pending is dropped and flagged in overflow.
module record_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int CH_ID_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           wordLimit,
    input  logic [NUM_CH-1:0]     chDataValid,
    input  logic [32*NUM_CH-1:0]  chData,
    output logic [NUM_CH-1:0]     chEnable,
    output logic [31:0]           outData,
    output logic [CH_ID_W-1:0]    outChan,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  outLast,
    output logic [NUM_CH-1:0]     overflow,
    output logic [15:0]           wordCount,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [CH_ID_W-1:0] PTR_INIT = CH_ID_W'(NUM_CH - 1);

    state_t               state_q, state_d;
    logic [NUM_CH-1:0]    prev_q;
    logic [NUM_CH-1:0]    pending_q, pending_d;
    logic [NUM_CH-1:0]    overflow_q, overflow_d;
    logic [31:0]          holding_q [NUM_CH];
    logic [15:0]          count_q, count_d;
    logic [31:0]          out_dat_q, out_dat_d;
    logic [CH_ID_W-1:0]   out_chan_q, out_chan_d;
    logic                 out_vld_q, out_vld_d;
    logic                 out_last_q, out_last_d;
    logic [CH_ID_W-1:0]   ptr_q, ptr_d;
    logic                 done_q, done_d;

    // Shared combinational terms
    logic [NUM_CH-1:0]    rise;
    logic [NUM_CH-1:0]    capture;
    logic [NUM_CH-1:0]    cap_ok;
    logic [NUM_CH-1:0]    lost;
    logic [NUM_CH-1:0]    gnt_oh;
    logic [NUM_CH-1:0]    pend_after;
    logic                 active;
    logic                 accept;
    logic                 finish;
    logic                 load_en;
    logic                 gnt_vld;
    logic [CH_ID_W-1:0]   gnt_idx;
    logic [CH_ID_W-1:0]   scan_idx;
    logic [15:0]          cnt_acc;
    logic                 last_lim;
    logic                 draining;
    logic                 last_drain;

    assign rise     = chDataValid & ~prev_q;
    assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign accept   = out_vld_q & outReady;
    // An accepted word marked last ends the session; nothing follows it.
    assign finish   = accept & out_last_q;
    assign load_en  = active && (!out_vld_q || outReady) && !finish;
    assign capture  = (state_q == S_RUN) ? rise : '0;
    assign gnt_oh   = (gnt_vld && load_en) ? (NUM_CH'(1) << gnt_idx) : '0;
    // A pending channel can take a new word only when its old one leaves this cycle.
    assign cap_ok   = capture & (~pending_q | gnt_oh);
    assign lost     = capture & pending_q & ~gnt_oh;
    assign pend_after = (pending_q & ~gnt_oh) | cap_ok;

    assign cnt_acc  = count_q + {15'd0, (accept && (count_q != 16'hFFFF))};
    // The register holds at most one word, so the loaded word is the (cnt_acc+1)-th accepted.
    assign last_lim = (wordLimit != 16'd0) &&
                      (({1'b0, cnt_acc} + 17'd1) == {1'b0, wordLimit});
    // A stop seen in RUN already counts as draining so the final word is tagged correctly.
    assign draining   = (state_q == S_DRAIN) || ((state_q == S_RUN) && stop);
    assign last_drain = draining && (pend_after == '0);

    // Round-robin search starting just after the last granted channel
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            scan_idx = CH_ID_W'((int'(ptr_q) + k) % NUM_CH);
            if (!gnt_vld && pending_q[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // Session state machine: next state and done pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                state_d = stop ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (finish) begin
                    state_d = S_IDLE;
                end else if (stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (finish || (!out_vld_q && (pending_q == '0))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_IDLE) && active;
    end

    // Datapath next-state: pending/overflow bookkeeping, counter and output register
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        out_dat_d  = out_dat_q;
        out_chan_d = out_chan_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        ptr_d      = ptr_q;
        case (state_q)
            S_ARM: begin
                pending_d  = '0;
                overflow_d = '0;
                count_d    = '0;
                out_dat_d  = '0;
                out_chan_d = '0;
                out_vld_d  = 1'b0;
                out_last_d = 1'b0;
                ptr_d      = PTR_INIT;
            end
            S_RUN, S_DRAIN: begin
                count_d    = cnt_acc;
                overflow_d = overflow_q | lost;
                pending_d  = pend_after;
                if (finish) begin
                    pending_d  = '0;
                    out_vld_d  = 1'b0;
                    out_last_d = 1'b0;
                end else if (load_en) begin
                    if (gnt_vld) begin
                        out_vld_d  = 1'b1;
                        out_dat_d  = holding_q[gnt_idx];
                        out_chan_d = gnt_idx;
                        out_last_d = last_lim || last_drain;
                        ptr_d      = gnt_idx;
                    end else begin
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                    end
                end
            end
            default: begin
                out_vld_d  = 1'b0;
                out_last_d = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            count_q    <= '0;
            out_dat_q  <= '0;
            out_chan_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            ptr_q      <= PTR_INIT;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= chDataValid;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            out_dat_q  <= out_dat_d;
            out_chan_q <= out_chan_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
        end
    end

    // Per-channel holding registers, written only when the new word is accepted
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                holding_q[i] <= '0;
            end else if (cap_ok[i]) begin
                holding_q[i] <= chData[32*i +: 32];
            end
        end
    end

    assign chEnable  = (state_q == S_RUN) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
    assign outData   = out_dat_q;
    assign outChan   = out_chan_q;
    assign outValid  = out_vld_q;
    assign outLast   = out_last_q;
    assign overflow  = overflow_q;
    assign wordCount = count_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_record_arbiter.sv
// Purpose: directed bench for record_arbiter with a scoreboard queue and a decoupled monitor.
// Latency: expected words carry an optional exact cycle for the latency case.
// Backpressure: outReady is driven per scenario; the monitor pops only on outValid&outReady.
module tb_record_arbiter;

    localparam int NUM_CH  = 4;
    localparam int CH_ID_W = 2;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 stop;
    logic [15:0]          wordLimit;
    logic [NUM_CH-1:0]    chDataValid;
    logic [32*NUM_CH-1:0] chData;
    logic [NUM_CH-1:0]    chEnable;
    logic [31:0]          outData;
    logic [CH_ID_W-1:0]   outChan;
    logic                 outValid;
    logic                 outReady;
    logic                 outLast;
    logic [NUM_CH-1:0]    overflow;
    logic [15:0]          wordCount;
    logic                 busy;
    logic                 done;

    record_arbiter #(.NUM_CH(NUM_CH), .CH_ID_W(CH_ID_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .wordLimit(wordLimit),
        .chDataValid(chDataValid), .chData(chData), .chEnable(chEnable),
        .outData(outData), .outChan(outChan), .outValid(outValid), .outReady(outReady),
        .outLast(outLast), .overflow(overflow), .wordCount(wordCount), .busy(busy), .done(done)
    );

    typedef struct {
        logic [31:0]        dat;
        logic [CH_ID_W-1:0] ch;
        logic               last;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted word must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && outValid && outReady) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_word: got dat=%h ch=%0d last=%0b, required none",
                         outData, outChan, outLast);
            end else begin
                mon_e = sb.pop_front();
                if (outData === mon_e.dat && outChan === mon_e.ch && outLast === mon_e.last &&
                    (mon_e.cyc < 0 || mon_e.cyc == cyc)) begin
                    n_pass++;
                end else begin
                    $display("FAIL stream_word: got dat=%h ch=%0d last=%0b cyc=%0d, required dat=%h ch=%0d last=%0b cyc=%0d",
                             outData, outChan, outLast, cyc, mon_e.dat, mon_e.ch, mon_e.last, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] dat, input int ch, input logic last, input int c);
        exp_t e;
        e.dat  = dat;
        e.ch   = CH_ID_W'(ch);
        e.last = last;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [31:0] val);
        chData[32*ch +: 32] = val;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask);
        chDataValid = mask;
        tick();
        chDataValid = '0;
        tick();
    endtask

    task automatic start_session(input logic [15:0] lim);
        wordLimit = lim;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string name);
        int seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        chk({name, "_done_pulse"}, 32'(seen), 32'd1);
        tick();
        @(negedge clk);
        chk({name, "_done_single"}, {31'd0, done}, 32'd0);
        chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic end_session(input string name);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(name);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; stop = 1'b0; wordLimit = '0;
        chDataValid = '0; chData = '0; outReady = 1'b0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outValid", {31'd0, outValid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_chEnable", {28'd0, chEnable}, 32'd0);
        chk("rst_overflow", {28'd0, overflow}, 32'd0);
        chk("rst_wordCount", {16'd0, wordCount}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Two channels rising together: ch0 first at n+2, ch2 at n+3
        tick();
        outReady = 1'b1;
        start_session(16'd0);
        @(negedge clk);
        chk("run_chEnable", {28'd0, chEnable}, 32'h0000_000F);
        tick();
        set_data(0, 32'hA5A5A5A5);
        set_data(2, 32'h12345678);
        n = cyc;
        push(32'hA5A5A5A5, 0, 1'b0, n + 2);
        push(32'h12345678, 2, 1'b0, n + 3);
        pulse(4'b0101);
        repeat (4) tick();
        @(negedge clk);
        chk("t1_wordCount", {16'd0, wordCount}, 32'd2);
        end_session("t1");

        // Stalled output: ch1 rises twice, second word lost
        outReady = 1'b0;
        start_session(16'd0);
        set_data(3, 32'hCAFE0003);
        push(32'hCAFE0003, 3, 1'b0, -1);
        pulse(4'b1000);
        set_data(1, 32'h0000_0001);
        push(32'h0000_0001, 1, 1'b0, -1);
        pulse(4'b0010);
        set_data(1, 32'h0000_0002);
        pulse(4'b0010);
        @(negedge clk);
        chk("t2_overflow_set", {28'd0, overflow}, 32'h0000_0002);
        tick();
        outReady = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("t2_wordCount", {16'd0, wordCount}, 32'd2);
        end_session("t2");
        chk("t2_overflow_sticky", {28'd0, overflow}, 32'h0000_0002);

        // Word limit 3 with five words queued
        outReady = 1'b0;
        start_session(16'd3);
        @(negedge clk);
        chk("t3_overflow_cleared", {28'd0, overflow}, 32'd0);
        tick();
        for (int c = 0; c < NUM_CH; c++) set_data(c, 32'h30 + 32'(c));
        chDataValid = 4'b1111;
        tick();
        chDataValid = '0;
        tick();
        set_data(0, 32'h34);
        pulse(4'b0001);
        push(32'h30, 0, 1'b0, -1);
        push(32'h31, 1, 1'b0, -1);
        push(32'h32, 2, 1'b1, -1);
        outReady = 1'b1;
        wait_done("t3");
        chk("t3_wordCount", {16'd0, wordCount}, 32'd3);
        chk("t3_outValid", {31'd0, outValid}, 32'd0);

        // Stop with two words pending
        outReady = 1'b0;
        start_session(16'd0);
        set_data(1, 32'h41);
        set_data(3, 32'h43);
        chDataValid = 4'b1010;
        tick();
        chDataValid = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("t4_chEnable_off", {28'd0, chEnable}, 32'd0);
        chk("t4_busy_drain", {31'd0, busy}, 32'd1);
        push(32'h41, 1, 1'b0, -1);
        push(32'h43, 3, 1'b1, -1);
        tick();
        outReady = 1'b1;
        wait_done("t4");

        // All channels every 33 cycles: strict 0,1,2,3 order
        outReady = 1'b1;
        start_session(16'd0);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_data(c, 32'h500 + 32'(r * 16 + c));
                push(32'h500 + 32'(r * 16 + c), c, 1'b0, -1);
            end
            chDataValid = 4'b1111;
            tick();
            chDataValid = '0;
            repeat (32) tick();
        end
        @(negedge clk);
        chk("t5_overflow", {28'd0, overflow}, 32'd0);
        chk("t5_wordCount", {16'd0, wordCount}, 32'd8);
        end_session("t5");

        // Reset while output stalled with an overflow flagged
        outReady = 1'b0;
        start_session(16'd0);
        set_data(0, 32'h60);
        pulse(4'b0001);
        set_data(1, 32'h61);
        pulse(4'b0010);
        set_data(1, 32'h62);
        pulse(4'b0010);
        @(negedge clk);
        chk("t6_outValid_pre", {31'd0, outValid}, 32'd1);
        chk("t6_overflow_pre", {28'd0, overflow}, 32'h0000_0002);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_outValid_rst", {31'd0, outValid}, 32'd0);
        chk("t6_busy_rst", {31'd0, busy}, 32'd0);
        chk("t6_overflow_rst", {28'd0, overflow}, 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
